// File: rtl/pool_lin_reader.sv
// pool_lin_reader: captures the pooled 3x3 feature vector into a private shadow and
// streams it element by element over valid/ready. Build option: POOL_LIN_READER_RELU_EN.
module pool_lin_reader #(
    parameter int N_ELEM = 9,
    parameter int DW     = 8,
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_ELEM*DW-1:0]   pool_lin_reg,
    output logic [DW-1:0]          out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_SEND  = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    logic                  state_q,   state_d;
    logic [N_ELEM*DW-1:0]  shadow_q,  shadow_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic                  done_q,    done_d;
    logic                  overrun_q, overrun_d;

    logic                  sending;
    logic                  handshake;
    logic                  at_last;
    logic [DW-1:0]         elem_sel;
    logic [DW-1:0]         elem_out;

    assign sending   = (state_q == ST_SEND);
    assign at_last   = (idx_q == LAST_IDX);
    assign handshake = sending & out_ready;

    // NOTE: every variable written in an always_comb gets a default first, otherwise an
    // untaken branch leaves it holding its old value and a latch is inferred.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shadow_d  = pool_lin_reg;
                    idx_d     = '0;
                    state_d   = ST_SEND;
                    overrun_d = 1'b0;
                end
            end
            ST_SEND: begin
                // The shadow is owned by the stream until the last handshake.
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Explicit compare-select keeps the index in range without a variable part-select.
    always_comb begin
        elem_sel = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            if (idx_q == IDX_W'(k)) begin
                elem_sel = shadow_q[k*DW +: DW];
            end
        end
    end

`ifdef POOL_LIN_READER_RELU_EN
    assign elem_out = elem_sel[DW-1] ? '0 : elem_sel;
`else
    assign elem_out = elem_sel;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would create order-dependent races.
    // The shadow is a handful of flops, not a RAM, so it is reset along with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = sending;
    assign busy      = sending;
    assign out_idx   = idx_q;
    assign out_last  = sending & at_last;
    assign out_data  = sending ? elem_out : '0;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
